// File: rtl/mul_pkg.sv
// Shared constants for the multiplier sequencer: datapath commands, FSM state
// encodings and operand/product widths.
package mul_pkg;

    localparam int unsigned OP_W     = 32;
    localparam int unsigned PROD_W   = 64;
    localparam int unsigned ITER_DEF = 32;
    localparam int unsigned SIG_W    = 6;
    localparam int unsigned ST_W     = 3;

    localparam logic [SIG_W-1:0] SIG_HOLD = 6'b011001;
    localparam logic [SIG_W-1:0] SIG_STEP = 6'b111111;

    // Sequencer states, kept as plain constants for legacy tools.
    localparam logic [ST_W-1:0] IDLE    = 3'd0;
    localparam logic [ST_W-1:0] CLEAR   = 3'd1;
    localparam logic [ST_W-1:0] RUN     = 3'd2;
    localparam logic [ST_W-1:0] CAPTURE = 3'd3;
    localparam logic [ST_W-1:0] DONE    = 3'd4;

endpackage

// File: rtl/mul_sequencer_if.sv
// Bundle of the requester, response and datapath signals around mul_sequencer.
// The slave view belongs to the sequencer; the master view belongs to its surroundings.
interface mul_sequencer_if;
    import mul_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_a;
    logic [OP_W-1:0]   req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_a;
    logic [OP_W-1:0]   req1_b;

    logic              mul_clr;
    logic [SIG_W-1:0]  mul_signal;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] mul_dout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [PROD_W-1:0] rsp_data;
    logic              busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  mul_dout, rsp_ready,
        output req0_ready, req1_ready, mul_clr, mul_signal, mul_a, mul_b,
        output rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output mul_dout, rsp_ready,
        input  req0_ready, req1_ready, mul_clr, mul_signal, mul_a, mul_b,
        input  rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: with both requesters valid the one not granted
// last wins; the pointer only moves when the grant is actually taken.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    input  logic       accept,
    output logic       grant_c,
    output logic       pointer_nxt_c
);

    always_comb begin
        grant_c = 1'b0;
        if (valid == 2'b11) begin
            grant_c = ~pointer;
        end else if (valid[1]) begin
            grant_c = 1'b1;
        end
        pointer_nxt_c = accept ? grant_c : pointer;
    end

endmodule

// File: rtl/mul_sequencer.sv
// Shares one shift-add multiplier datapath between two requesters: arbitrate,
// clear, step with pre-shifted operands, capture the product, hand it back.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned ITER       = ITER_DEF,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [OP_W-1:0]   a_sh;
    logic [OP_W-1:0]   b_sh;
    logic [CNT_W-1:0]  cnt;
    logic              ptr;
    logic              id;
    logic [PROD_W-1:0] rsp_data_q;

    logic [1:0]        valid_c;
    logic              accept_c;
    logic              grant_c;
    logic              ptr_nxt_c;
    logic              run_last_c;

    assign valid_c  = {bus.req1_valid, bus.req0_valid};
    // Ready is gated by reset so no transfer can be signalled while held in reset.
    assign accept_c = (state == IDLE) && (|valid_c) && reset;

    rr_arbiter2 u_arb (
        .valid         (valid_c),
        .pointer       (ptr),
        .accept        (accept_c),
        .grant_c       (grant_c),
        .pointer_nxt_c (ptr_nxt_c)
    );

    // Last step: counter exhausted, or no multiplier bits left after this shift.
    assign run_last_c = (cnt == CNT_W'(ITER - 1)) ||
                        (EARLY_EXIT && ((b_sh >> 1) == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.mul_clr    = 1'b0;
        bus.mul_signal = SIG_HOLD;
        bus.mul_a      = '0;
        bus.mul_b      = '0;
        bus.rsp_valid  = 1'b0;
        bus.busy       = 1'b1;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.mul_clr    = 1'b1;
                bus.busy       = 1'b0;
                bus.req0_ready = accept_c && !grant_c;
                bus.req1_ready = accept_c && grant_c;
                if (accept_c) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                bus.mul_clr = 1'b1;
                state_nxt   = RUN;
            end
            RUN: begin
                bus.mul_signal = SIG_STEP;
                bus.mul_a      = a_sh;
                bus.mul_b      = b_sh;
                if (run_last_c) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = DONE;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                bus.mul_clr = 1'b1;
                bus.busy    = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    // Operand shifters, step counter, arbitration pointer and result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            cnt        <= '0;
            ptr        <= 1'b1;
            id         <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            ptr <= ptr_nxt_c;
            if (accept_c) begin
                a_sh <= grant_c ? bus.req1_a : bus.req0_a;
                b_sh <= grant_c ? bus.req1_b : bus.req0_b;
                id   <= grant_c;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CNT_W'(1);
            end
            if (state == CAPTURE) begin
                rsp_data_q <= bus.mul_dout;
            end
        end
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_id   = id;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural shift-add datapath model
// and hand-computed products, latencies and grant orders.
module tb_mul_sequencer;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mul_sequencer_if bus ();

    mul_sequencer #(.ITER(32), .EARLY_EXIT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Datapath model: cleared by mul_clr, adds the shifted multiplicand when mul_b[0] is set.
    logic [63:0] dp_acc;
    logic [31:0] dp_a0;
    logic [5:0]  dp_k;
    int          dp_a_err = 0;

    always @(posedge clk) begin
        if (bus.mul_clr === 1'b1) begin
            dp_acc <= '0;
            dp_k   <= '0;
        end else if (bus.mul_signal === SIG_STEP) begin
            dp_k <= dp_k + 6'd1;
            if (dp_k == 6'd0) begin
                dp_a0 <= bus.mul_a;
                if (bus.mul_b[0]) dp_acc <= dp_acc + 64'(bus.mul_a);
            end else begin
                if (bus.mul_b[0]) dp_acc <= dp_acc + (64'(dp_a0) << dp_k);
                if (bus.mul_a !== 32'(dp_a0 << dp_k)) dp_a_err <= dp_a_err + 1;
            end
        end
    end

    assign bus.mul_dout = dp_acc;

    task automatic wait_rsp(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(posedge clk); #1;
            n++;
            if (bus.rsp_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // One isolated request from requester rid, acknowledged as soon as it appears.
    task automatic do_req(input string name, input bit rid, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_p, input int exp_r);
        int n;
        bit ok;
        int err0;
        logic [1:0] exp_rdy;
        err0    = dp_a_err;
        exp_rdy = rid ? 2'b10 : 2'b01;
        if (rid) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin n_fail++; $display("FAIL %s ready: got %b expected %b", name, {bus.req1_ready, bus.req0_ready}, exp_rdy); end
        @(posedge clk); #1;
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL %s ready_pulse: got %b expected 00", name, {bus.req1_ready, bus.req0_ready}); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(60, n, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL %s timeout: got no rsp_valid expected one within 60 cycles", name); end
        n_checks++; if (n !== exp_r + 2) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, n, exp_r + 2); end
        n_checks++; if (bus.rsp_id !== rid) begin n_fail++; $display("FAIL %s rsp_id: got %b expected %b", name, bus.rsp_id, rid); end
        n_checks++; if (bus.rsp_data !== exp_p) begin n_fail++; $display("FAIL %s rsp_data: got %h expected %h", name, bus.rsp_data, exp_p); end
        n_checks++; if (dp_a_err !== err0) begin n_fail++; $display("FAIL %s mul_a_shift: got %0d bad steps expected 0", name, dp_a_err - err0); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL %s release: got valid/busy %b expected 00", name, {bus.rsp_valid, bus.busy}); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd7;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd9;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
        n_checks++; if (bus.mul_clr !== 1'b1) begin n_fail++; $display("FAIL reset_mul_clr: got %b expected 1", bus.mul_clr); end
        n_checks++; if (bus.mul_signal !== 6'b011001) begin n_fail++; $display("FAIL reset_mul_signal: got %b expected 011001", bus.mul_signal); end
        n_checks++; if ({bus.mul_a, bus.mul_b} !== 64'd0) begin n_fail++; $display("FAIL reset_mul_ab: got %h expected 0", {bus.mul_a, bus.mul_b}); end
        n_checks++; if ({bus.rsp_id, bus.rsp_data} !== 65'd0) begin n_fail++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_id, bus.rsp_data}); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_basic();
        do_req("basic_3x5", 1'b0, 32'd3, 32'd5, 64'd15, 3);
    endtask

    task automatic test_full();
        do_req("full_ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
    endtask

    task automatic test_edges();
        do_req("b_zero", 1'b0, 32'hDEAD_BEEF, 32'd0, 64'd0, 1);
        do_req("b_one", 1'b1, 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 1);
    endtask

    // Both requesters held valid with rsp_ready high: grants must alternate starting at req0.
    task automatic test_back_to_back();
        int n;
        bit ok;
        bit exp_id;
        logic [63:0] exp_p;
        int exp_gap;
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd7;   bus.req0_b = 32'd6;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd100; bus.req1_b = 32'd3;
        for (int i = 0; i < 4; i++) begin
            exp_id  = i[0];
            exp_p   = exp_id ? 64'd300 : 64'd42;
            exp_gap = exp_id ? 6 : 7;
            wait_rsp(60, n, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout_%0d: got no rsp_valid expected one", i); end
            n_checks++; if (bus.rsp_id !== exp_id) begin n_fail++; $display("FAIL b2b_id_%0d: got %b expected %b", i, bus.rsp_id, exp_id); end
            n_checks++; if (bus.rsp_data !== exp_p) begin n_fail++; $display("FAIL b2b_data_%0d: got %h expected %h", i, bus.rsp_data, exp_p); end
            if (i > 0) begin
                n_checks++; if (n !== exp_gap) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d expected %0d", i, n, exp_gap); end
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got busy %b expected 0", bus.busy); end
    endtask

    // Response back-pressure: result must hold and no new request may be accepted.
    task automatic test_hold();
        int n;
        bit ok;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_rsp(60, n, ok);
        n_checks++; if (!ok || n !== 6) begin n_fail++; $display("FAIL hold_latency: got %0d (seen %b) expected 6", n, ok); end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++; if ({bus.rsp_valid, bus.rsp_id, bus.req1_ready, bus.req0_ready, bus.rsp_data} !== {4'b1000, 64'd81}) begin n_fail++; $display("FAIL hold_stable_%0d: got v/id/rdy %b data %h expected 1000 data 51", i, {bus.rsp_valid, bus.rsp_id, bus.req1_ready, bus.req0_ready}, bus.rsp_data); end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL hold_release: got valid/busy %b expected 00", {bus.rsp_valid, bus.busy}); end
    endtask

    // Reset in the middle of RUN: abort, no stale response, pointer back to req0-first.
    task automatic test_reset_mid_run();
        int stale;
        bus.req0_valid = 1'b1; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        n_checks++; if (bus.mul_signal !== 6'b111111 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrun_step: got signal %b busy %b expected 111111 1", bus.mul_signal, bus.busy); end
        n_checks++; if ({bus.mul_a, bus.mul_b} !== {32'hFFFF_FC00, 32'h003F_FFFF}) begin n_fail++; $display("FAIL midrun_operands: got %h expected fffffc00003fffff", {bus.mul_a, bus.mul_b}); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({bus.busy, bus.rsp_valid, bus.mul_clr} !== 3'b001) begin n_fail++; $display("FAIL async_reset_ctrl: got busy/valid/clr %b expected 001", {bus.busy, bus.rsp_valid, bus.mul_clr}); end
        n_checks++; if ({bus.mul_signal, bus.mul_a, bus.mul_b} !== {6'b011001, 64'd0}) begin n_fail++; $display("FAIL async_reset_dp: got %h expected %h", {bus.mul_signal, bus.mul_a, bus.mul_b}, {6'b011001, 64'd0}); end
        n_checks++; if ({bus.rsp_id, bus.rsp_data} !== 65'd0) begin n_fail++; $display("FAIL async_reset_rsp: got %h expected 0", {bus.rsp_id, bus.rsp_data}); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL no_stale_rsp: got %0d active cycles expected 0", stale); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_pointer: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        #1;
        do_req("post_reset", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 17);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        test_reset();
        test_basic();
        test_full();
        test_edges();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish before 200000");
        $fatal(1);
    end

endmodule
